halut_decoder_accum: RTL and testbench
======================================

Name: halut_decoder_accum

Overview:
- Decoder-side unit of the halut matmul datapath.
- Consumes the stream of per-codebook prototype indices (c, k) that the encoder produces for one input row.
- Looks up the LUT entries for the columns this unit owns and accumulates them over all C codebooks.
- After the last codebook, emits one accumulated result per owned column over a valid/ready port.
- One instance per decoder unit; M/DecoderUnits columns each.

Parameters:
- K, 16, prototypes per codebook (k index range)
- C, 32, codebooks per row (c index range)
- DataTypeWidth, 16, signed LUT entry width
- ColsPerUnit, 2, columns owned by this unit (M/DecoderUnits, >=1)
- AccWidth, 21, accumulator/result width (DataTypeWidth+$clog2(C))

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- lut_we_i  in  1  LUT write strobe
- lut_col_i  in  max(1,$clog2(ColsPerUnit))  LUT write column
- lut_c_i  in  $clog2(C)  LUT write codebook
- lut_k_i  in  $clog2(K)  LUT write prototype
- lut_data_i  in  DataTypeWidth  LUT write data, signed
- enc_valid_i  in  1  encoder index valid
- enc_ready_o  out  1  encoder index ready
- enc_c_i  in  $clog2(C)  codebook of this index
- enc_k_i  in  $clog2(K)  selected prototype
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result ready
- res_col_o  out  max(1,$clog2(ColsPerUnit))  column of result
- res_data_o  out  AccWidth  accumulated result, signed
- busy_o  out  1  row in progress or draining
- err_o  out  1  sticky error flag

Behaviour:
- Reset values:
  - enc_ready_o=0 in the reset cycle.
  - res_valid_o=0, res_col_o=0, res_data_o=0, busy_o=0, err_o=0.
  - Accumulators=0, expected codebook counter=0, state=ACCUM.
  - LUT contents are not reset; they are retained across reset.
- LUT:
  - K*C entries per column; write is one cycle and takes effect at the clock edge.
  - A write is accepted only when busy_o=0. A write while busy_o=1 is dropped and sets err_o.
- enc_ready_o = (state==ACCUM) && !last_pending && !lut_we_i. A LUT write therefore always wins over an index handshake in the same cycle.
- Handshake at cycle t (enc_valid_i && enc_ready_o):
  - All ColsPerUnit LUT entries for (enc_c_i, enc_k_i) are read into a register.
  - At t+1 each column accumulator adds its sign-extended entry.
  - Throughput is one index per cycle.
- Ordering:
  - Indices must arrive with enc_c_i = 0,1,...,C-1.
  - If enc_c_i != expected counter, err_o is set. The entry is still accumulated and the counter still advances.
  - The counter wraps from C-1 to 0.
- busy_o:
  - Set on the first accepted index of a row.
  - Cleared when the final result handshake completes.
- Row end:
  - Accepting the index with counter==C-1 sets last_pending.
  - Its accumulation happens at t+1.
  - At t+2 state goes to DRAIN and res_valid_o=1, with res_col_o=0 and res_data_o=acc[0].
- DRAIN:
  - Each res_valid_o && res_ready_i handshake advances res_col_o.
  - Outputs are stable while res_ready_i=0.
  - After the handshake on column ColsPerUnit-1, in the next cycle: accumulators=0, counter=0, last_pending=0, state=ACCUM, res_valid_o=0, busy_o=0.
  - Minimum result latency: last index handshake to first res_valid_o is 2 cycles.
- Arithmetic:
  - Two's complement, AccWidth bits.
  - C entries of DataTypeWidth bits cannot overflow AccWidth; no saturation.
- Reset mid-row or mid-drain: all state returns to reset values next cycle; the partial row is discarded and the LUT is kept.
- err_o is cleared only by rst_i.

Test Plan:
- Load column 0 with entry(c,k)=c+1 and column 1 with entry=-(k+1). Send c=0..31, all k=3 -> col0=528, col1=-128; res_valid_o 2 cycles after last handshake.
- Load all entries as 0x7FFF. Send one row -> both results=32*32767=1048544, no wrap. Repeat with all 0x8000 -> -1048576.
- Hold res_ready_i=0 for 5 cycles in DRAIN -> res_col_o/res_data_o stable, enc_ready_o=0. Back-to-back row after drain -> fresh sums, no carry-over.
- Assert lut_we_i with enc_valid_i while busy_o=0 -> write lands, enc_ready_o=0 that cycle. Write with busy_o=1 -> LUT unchanged, err_o=1 and sticky.
- Send c sequence 0,1,5,3,... -> err_o=1 at the third handshake; row still completes after 32 indices.
- Assert rst_i after 10 indices -> busy_o=0, err_o=0. Then send a full row -> result equals a clean row's sum using the previously loaded LUT.

Source files
------------

// File: rtl/halut_decoder_accum.sv
// Halut decoder accumulator: per-column LUT lookup of encoder prototype
// indices, accumulated over all codebooks of a row, then drained one
// column result at a time over a valid/ready port.

// One owned column: its K*C LUT slice, read register and accumulator.
module halut_decoder_col #(
   parameter int DataTypeWidth = 16,
   parameter int AccWidth      = 21,
   parameter int AddrWidth     = 9
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     we_i,
   input  logic [AddrWidth-1:0]     waddr_i,
   input  logic [DataTypeWidth-1:0] wdata_i,
   input  logic                     rd_en_i,
   input  logic [AddrWidth-1:0]     raddr_i,
   input  logic                     acc_en_i,
   input  logic                     clr_i,
   output logic [AccWidth-1:0]      acc_o
);

   logic [DataTypeWidth-1:0] mem [2**AddrWidth];
   logic [DataTypeWidth-1:0] rd_q;

   // LUT storage; deliberately not reset so contents survive rst_i
   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   // entry for the accepted index, consumed by the accumulator next cycle
   always_ff @(posedge clk_i) begin
      if (rd_en_i) rd_q <= mem[raddr_i];
   end

   // sign-extended accumulation; width is sized so a full row cannot wrap
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) acc_o <= '0;
      else if (acc_en_i)  acc_o <= acc_o + {{(AccWidth-DataTypeWidth){rd_q[DataTypeWidth-1]}}, rd_q};
   end

endmodule

module halut_decoder_accum #(
   parameter int K             = 16,
   parameter int C             = 32,
   parameter int DataTypeWidth = 16,
   parameter int ColsPerUnit   = 2,
   parameter int AccWidth      = 21,
   localparam int CW  = (ColsPerUnit > 1) ? $clog2(ColsPerUnit) : 1,
   localparam int CBW = $clog2(C),
   localparam int KW  = $clog2(K)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     lut_we_i,
   input  logic [CW-1:0]            lut_col_i,
   input  logic [CBW-1:0]           lut_c_i,
   input  logic [KW-1:0]            lut_k_i,
   input  logic [DataTypeWidth-1:0] lut_data_i,
   input  logic                     enc_valid_i,
   output logic                     enc_ready_o,
   input  logic [CBW-1:0]           enc_c_i,
   input  logic [KW-1:0]            enc_k_i,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [CW-1:0]            res_col_o,
   output logic [AccWidth-1:0]      res_data_o,
   output logic                     busy_o,
   output logic                     err_o
);

   localparam int STAGES = 1;

   typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

   state_t                                state_q, state_d;
   logic [ColsPerUnit-1:0][AccWidth-1:0]  acc;
   logic [STAGES:0]                       vld_pipe, last_pipe;
   logic [STAGES:1]                       vld_q, last_q;
   logic [CBW-1:0]                        cnt_q;
   logic [CW-1:0]                         res_col_q;
   logic                                  last_pending_q, busy_q, err_q;
   logic                                  enc_hs, res_hs, last_col, drain_done, lut_wr_ok;

   assign enc_ready_o = (state_q == ST_ACCUM) && !last_pending_q && !lut_we_i && !rst_i;
   assign enc_hs      = enc_valid_i && enc_ready_o;
   assign res_valid_o = (state_q == ST_DRAIN);
   assign res_hs      = res_valid_o && res_ready_i;
   assign last_col    = (res_col_q == CW'(ColsPerUnit-1));
   assign drain_done  = res_hs && last_col;
   assign lut_wr_ok   = lut_we_i && !busy_q;
   assign res_col_o   = res_col_q;
   assign res_data_o  = res_valid_o ? acc[res_col_q] : '0;
   assign busy_o      = busy_q;
   assign err_o       = err_q;

   // index-valid and row-end tokens travel alongside the LUT read
   always_comb begin
      vld_pipe  = {vld_q, enc_hs};
      last_pipe = {last_q, enc_hs && (cnt_q == CBW'(C-1))};
   end

   genvar gi;
   generate
      for (gi = 0; gi < ColsPerUnit; gi++) begin : g_col
         halut_decoder_col #(
            .DataTypeWidth(DataTypeWidth),
            .AccWidth     (AccWidth),
            .AddrWidth    (CBW+KW)
         ) u_col (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .we_i    (lut_wr_ok && (lut_col_i == CW'(gi))),
            .waddr_i ({lut_c_i, lut_k_i}),
            .wdata_i (lut_data_i),
            .rd_en_i (enc_hs),
            .raddr_i ({enc_c_i, enc_k_i}),
            .acc_en_i(vld_pipe[STAGES]),
            .clr_i   (drain_done),
            .acc_o   (acc[gi])
         );
      end
   endgenerate

   // drain starts once the final entry has been accumulated
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACCUM: if (last_pipe[STAGES]) state_d = ST_DRAIN;
         ST_DRAIN: if (drain_done)        state_d = ST_ACCUM;
         default:                         state_d = ST_ACCUM;
      endcase
   end

   // control state: pipeline, codebook counter, row flags, result column
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_ACCUM;
         vld_q          <= '0;
         last_q         <= '0;
         cnt_q          <= '0;
         res_col_q      <= '0;
         last_pending_q <= 1'b0;
         busy_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_pipe[STAGES-1:0];
         last_q  <= last_pipe[STAGES-1:0];
         if (enc_hs) begin
            cnt_q  <= (cnt_q == CBW'(C-1)) ? '0 : cnt_q + 1'b1;
            busy_q <= 1'b1;
            if (enc_c_i != cnt_q) err_q <= 1'b1;
         end
         if (last_pipe[0])         last_pending_q <= 1'b1;
         if (lut_we_i && busy_q)   err_q <= 1'b1;
         if (res_hs)               res_col_q <= last_col ? '0 : res_col_q + 1'b1;
         if (drain_done) begin
            cnt_q          <= '0;
            last_pending_q <= 1'b0;
            busy_q         <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_halut_decoder_accum.sv
// Randomized bench for halut_decoder_accum against a table-based model:
// expected result per column is the plain sum of the model LUT entries
// selected by every accepted index of the row.
module tb_halut_decoder_accum;

   localparam int K = 16, C = 32, DW = 16, COLS = 2, AW = 21;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          lut_we_i;
   logic [0:0]    lut_col_i;
   logic [4:0]    lut_c_i;
   logic [3:0]    lut_k_i;
   logic [DW-1:0] lut_data_i;
   logic          enc_valid_i;
   logic          enc_ready_o;
   logic [4:0]    enc_c_i;
   logic [3:0]    enc_k_i;
   logic          res_valid_o;
   logic          res_ready_i;
   logic [0:0]    res_col_o;
   logic [AW-1:0] res_data_o;
   logic          busy_o;
   logic          err_o;

   halut_decoder_accum #(.K(K), .C(C), .DataTypeWidth(DW), .ColsPerUnit(COLS), .AccWidth(AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .lut_we_i(lut_we_i), .lut_col_i(lut_col_i),
      .lut_c_i(lut_c_i), .lut_k_i(lut_k_i), .lut_data_i(lut_data_i),
      .enc_valid_i(enc_valid_i), .enc_ready_o(enc_ready_o), .enc_c_i(enc_c_i), .enc_k_i(enc_k_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_col_o(res_col_o),
      .res_data_o(res_data_o), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int lut_m [COLS][C][K];
   int exp_acc [COLS];
   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask

   // one LUT write cycle; the model only takes it when the unit is idle
   task automatic lut_wr(input int col, input int c, input int k, input int d);
      logic signed [DW-1:0] s;
      bit                   take;
      s = d[DW-1:0];
      lut_we_i = 1'b1; lut_col_i = col[0:0]; lut_c_i = c[4:0]; lut_k_i = k[3:0]; lut_data_i = s;
      take = !busy_o;
      @(posedge clk_i); #1;
      lut_we_i = 1'b0;
      if (take) lut_m[col][c][k] = int'(s);
   endtask

   // mode 0: col0=c+1, col1=-(k+1); 1: all 0x7FFF; 2: all 0x8000; 3: random
   task automatic load_lut(input int mode);
      int d;
      for (int col = 0; col < COLS; col++)
         for (int c = 0; c < C; c++)
            for (int k = 0; k < K; k++) begin
               case (mode)
                  0:       d = (col == 0) ? c + 1 : -(k + 1);
                  1:       d = 32'h7FFF;
                  2:       d = 32'hFFFF_8000;
                  default: d = int'($urandom_range(0, 65535)) - 32768;
               endcase
               lut_wr(col, c, k, d);
            end
   endtask

   task automatic send_idx(input int c, input int k);
      int w = 0;
      enc_valid_i = 1'b1; enc_c_i = c[4:0]; enc_k_i = k[3:0];
      #1;
      while (!enc_ready_o && w < 50) begin
         @(posedge clk_i); #1; w++;
      end
      if (!enc_ready_o) begin
         chk("enc_ready_timeout", int'(enc_ready_o), 1);
         enc_valid_i = 1'b0;
         return;
      end
      @(posedge clk_i); #1;
      enc_valid_i = 1'b0;
      for (int j = 0; j < COLS; j++) exp_acc[j] += lut_m[j][c][k];
   endtask

   task automatic send_row_rand();
      for (int c = 0; c < C; c++) send_idx(c, int'($urandom_range(0, K-1)));
   endtask

   // collect all column results; optional latency check and DRAIN stall
   task automatic drain(input string tag, input bit chk_lat, input int stall);
      int w;
      logic [AW-1:0] d0;
      if (chk_lat) begin
         chk({tag, "_lat_t1"}, int'(res_valid_o), 0);
         @(posedge clk_i); #1;
         chk({tag, "_lat_t2"}, int'(res_valid_o), 1);
      end
      for (int j = 0; j < COLS; j++) begin
         w = 0;
         while (!res_valid_o && w < 50) begin
            @(posedge clk_i); #1; w++;
         end
         chk({tag, "_valid"}, int'(res_valid_o), 1);
         chk({tag, "_col"}, int'(res_col_o), j);
         chk({tag, "_data"}, int'($signed(res_data_o)), exp_acc[j]);
         if (j == 0 && stall > 0) begin
            d0 = res_data_o;
            enc_valid_i = 1'b1; enc_c_i = '0; enc_k_i = '0;
            for (int s = 0; s < stall; s++) begin
               @(posedge clk_i); #1;
               chk({tag, "_stall_col"}, int'(res_col_o), 0);
               chk({tag, "_stall_data"}, int'(res_data_o), int'(d0));
               chk({tag, "_stall_rdy"}, int'(enc_ready_o), 0);
            end
            enc_valid_i = 1'b0;
         end
         res_ready_i = 1'b1;
         @(posedge clk_i); #1;
         res_ready_i = 1'b0;
      end
      chk({tag, "_busy_end"}, int'(busy_o), 0);
      chk({tag, "_valid_end"}, int'(res_valid_o), 0);
      for (int j = 0; j < COLS; j++) exp_acc[j] = 0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      #1;
      chk("rst_enc_ready", int'(enc_ready_o), 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      for (int j = 0; j < COLS; j++) exp_acc[j] = 0;
   endtask

   initial begin
      rst_i = 1'b1; lut_we_i = 1'b0; lut_col_i = '0; lut_c_i = '0; lut_k_i = '0; lut_data_i = '0;
      enc_valid_i = 1'b0; enc_c_i = '0; enc_k_i = '0; res_ready_i = 1'b0;
      for (int j = 0; j < COLS; j++) exp_acc[j] = 0;

      // reset state
      @(posedge clk_i); #1;
      chk("rst_enc_ready", int'(enc_ready_o), 0);
      chk("rst_res_valid", int'(res_valid_o), 0);
      chk("rst_res_col", int'(res_col_o), 0);
      chk("rst_res_data", int'(res_data_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_err", int'(err_o), 0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // structured LUT, constant k: sums are 1+..+32 and 32*-(3+1)
      load_lut(0);
      for (int c = 0; c < C; c++) send_idx(c, 3);
      chk("plan_col0_model", exp_acc[0], 528);
      chk("plan_col1_model", exp_acc[1], -128);
      drain("plan", 1'b1, 0);

      // largest positive and negative rows must not wrap
      load_lut(1);
      send_row_rand();
      drain("max_pos", 1'b1, 0);
      load_lut(2);
      send_row_rand();
      drain("max_neg", 1'b1, 5);

      // random LUT, back-to-back rows
      load_lut(3);
      for (int r = 0; r < 3; r++) begin
         send_row_rand();
         drain("rand_row", 1'b1, r);
      end

      // idle LUT write beats a simultaneous index; busy write is dropped
      begin
         int kw;
         kw = int'($urandom_range(0, K-1));
         lut_we_i = 1'b1; lut_col_i = 1'b1; lut_c_i = '0; lut_k_i = kw[3:0]; lut_data_i = 16'h1234;
         enc_valid_i = 1'b1; enc_c_i = '0; enc_k_i = kw[3:0];
         #1;
         chk("we_blocks_ready", int'(enc_ready_o), 0);
         @(posedge clk_i); #1;
         lut_we_i = 1'b0;
         lut_m[1][0][kw] = 32'h1234;
         send_idx(0, kw);
         for (int c = 1; c < 6; c++) send_idx(c, int'($urandom_range(0, K-1)));
         chk("busy_mid_row", int'(busy_o), 1);
         chk("err_before_busy_wr", int'(err_o), 0);
         lut_wr(0, 31, 7, 32'h0555);
         chk("err_busy_wr", int'(err_o), 1);
         for (int c = 6; c < C-1; c++) send_idx(c, int'($urandom_range(0, K-1)));
         send_idx(C-1, 7);
         drain("wr_rules", 1'b1, 0);
         chk("err_sticky", int'(err_o), 1);
      end

      // out-of-order codebook: error on the third index, row still completes
      do_reset();
      chk("err_cleared", int'(err_o), 0);
      for (int i = 0; i < C; i++) begin
         send_idx((i == 2) ? 5 : i, int'($urandom_range(0, K-1)));
         if (i == 1) chk("order_err_2nd", int'(err_o), 0);
         if (i == 2) chk("order_err_3rd", int'(err_o), 1);
      end
      drain("order", 1'b1, 0);

      // reset mid-row discards the partial sum but keeps the LUT
      for (int c = 0; c < 10; c++) send_idx(c, int'($urandom_range(0, K-1)));
      do_reset();
      chk("midrst_busy", int'(busy_o), 0);
      chk("midrst_err", int'(err_o), 0);
      chk("midrst_valid", int'(res_valid_o), 0);
      send_row_rand();
      drain("after_rst", 1'b1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
